rr_mux_nbit: RTL and testbench
==============================

RR_MUX_NBIT -- requirements
Module: rr_mux_nbit

Interface
REQ-001 SHALL provide parameter NUM_OF_INPUTS, default 5: number of input channels; legal range 2..16.
REQ-002 SHALL provide parameter INPUT_WIDTH, default 4: data width per channel in bits; legal range >= 1.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_data  input  INPUT_WIDTH x NUM_OF_INPUTS (unpacked array)  per-channel data.
REQ-007 in_valid  input  NUM_OF_INPUTS  per-channel request; bit i qualifies in_data[i].
REQ-008 in_ready  output  NUM_OF_INPUTS  per-channel accept; bit i high means in_data[i] is taken this cycle.
REQ-009 out_data  output  INPUT_WIDTH  registered selected data.
REQ-010 out_sel  output  $clog2(NUM_OF_INPUTS)  registered index of the channel that sourced out_data.
REQ-011 out_valid  output  1  out_data/out_sel hold a beat.
REQ-012 out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both high.

Function
REQ-013 Transfer on channel i SHALL occur exactly when in_valid[i] and in_ready[i] are both high at a rising clk edge.
REQ-014 load_en SHALL equal (!out_valid || out_ready); the output register may be loaded only when load_en is high.
REQ-015 Arbitration SHALL be round-robin: grant goes to the first channel with in_valid high, searching ptr, ptr+1, ... NUM_OF_INPUTS-1, 0, ... ptr-1.
REQ-016 in_ready SHALL be combinational, one-hot or all-zero, and equal to the grant vector gated by load_en.
REQ-017 in_ready SHALL NOT depend combinationally on in_data.
REQ-018 With load_en high and a grant to channel g: next edge SHALL set out_data = in_data[g], out_sel = g, out_valid = 1, and ptr = (g+1) mod NUM_OF_INPUTS.
REQ-019 ptr SHALL wrap from NUM_OF_INPUTS-1 to 0; it is not required to be a power of two.
REQ-020 With load_en high and no in_valid bit set: next edge SHALL set out_valid = 0; out_data, out_sel and ptr SHALL hold.
REQ-021 With load_en low (out_valid=1, out_ready=0): out_data, out_sel, out_valid and ptr SHALL hold; all in_ready SHALL be 0.
REQ-022 Simultaneous consume and load (out_valid=1, out_ready=1, request present) SHALL replace the beat in the same edge with no bubble; sustained throughput SHALL be 1 beat/cycle.
REQ-023 Latency SHALL be 1 cycle from the accepting edge to out_valid high with the new data.
REQ-024 Once out_valid is high, out_data and out_sel SHALL remain stable until the beat is consumed.
REQ-025 ptr SHALL advance only on a granted transfer, never on idle cycles.
REQ-026 No channel with in_valid continuously high SHALL wait more than NUM_OF_INPUTS-1 transfers for a grant.

Reset
REQ-027 With rst high at a rising edge: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
REQ-028 rst SHALL take priority over every other event; a beat held in the output register during reset SHALL be discarded.
REQ-029 While rst is high, in_ready SHALL be all-zero.
REQ-030 After rst deasserts, the first grant SHALL search from channel 0.

Verification
REQ-031 Reset: N=5, W=4; assert rst for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=00000 throughout.
REQ-032 Full contention: all in_valid=1, in_data[i]=i+1, out_ready=1 -> out_sel sequence 0,1,2,3,4,0; out_data 1,2,3,4,5,1; out_valid high every cycle from the 2nd edge.
REQ-033 Backpressure: a beat from ch2 (data 0xA) is held with out_ready=0 for 3 cycles -> out_data=0xA, out_sel=2 stable, in_ready=00000; on release, ch3 is granted next.
REQ-034 Sparse/wrap: ptr=4, only in_valid[1]=1 -> ch1 granted, ptr becomes 2; then no requests -> out_valid drops to 0 after the consume, ptr stays 2.
REQ-035 Reset mid-stream: rst asserted while out_valid=1, out_sel=3 -> next edge out_valid=0, out_data=0, out_sel=0; after release with all requests, first grant is ch0.
REQ-036 Parameter sweep: N=2, W=1 and N=16, W=32 -> round-robin order and 1 beat/cycle throughput as in REQ-032.

Source files
------------

// File: rtl/rr_mux_nbit_if.sv
// rtl/rr_mux_nbit_if.sv - channel request bus and output beat bus for rr_mux_nbit
interface rr_mux_nbit_if #(
   parameter int NUM_OF_INPUTS = 5,
   parameter int INPUT_WIDTH   = 4
);
   localparam int SEL_W = $clog2(NUM_OF_INPUTS);

   logic [INPUT_WIDTH-1:0]   in_data [NUM_OF_INPUTS];
   logic [NUM_OF_INPUTS-1:0] in_valid;
   logic [NUM_OF_INPUTS-1:0] in_ready;
   logic [INPUT_WIDTH-1:0]   out_data;
   logic [SEL_W-1:0]         out_sel;
   logic                     out_valid;
   logic                     out_ready;

   // Producer/consumer side: drives requests and the downstream ready
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_sel, out_valid
   );

   // Arbiter side
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_sel, out_valid
   );
endinterface

// File: rtl/rr_mux_nbit.sv
// rtl/rr_mux_nbit.sv - round-robin N-channel mux with a registered output beat
module rr_mux_nbit #(
   parameter int NUM_OF_INPUTS = 5,
   parameter int INPUT_WIDTH   = 4
) (
   input  logic          clk,
   input  logic          rst,
   rr_mux_nbit_if.slave  bus
);
   localparam int SEL_W = $clog2(NUM_OF_INPUTS);

   logic [INPUT_WIDTH-1:0]   out_data_q, out_data_d;
   logic [SEL_W-1:0]         out_sel_q, out_sel_d;
   logic                     out_valid_q, out_valid_d;
   logic [SEL_W-1:0]         ptr_q, ptr_d;

   logic                     load_en;
   logic                     grant_any;
   logic [SEL_W-1:0]         grant_idx;
   logic [NUM_OF_INPUTS-1:0] grant_vec;

   // Output register can take a new beat when empty or being drained this cycle
   assign load_en = !out_valid_q || bus.out_ready;

   // Round-robin search: first pass covers ptr..N-1, second pass wraps to 0..ptr-1
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      grant_vec = '0;
      for (int i = 0; i < NUM_OF_INPUTS; i++) begin
         if (!grant_any && bus.in_valid[i] && (i >= int'(ptr_q))) begin
            grant_any    = 1'b1;
            grant_idx    = SEL_W'(i);
            grant_vec[i] = 1'b1;
         end
      end
      for (int i = 0; i < NUM_OF_INPUTS; i++) begin
         if (!grant_any && bus.in_valid[i] && (i < int'(ptr_q))) begin
            grant_any    = 1'b1;
            grant_idx    = SEL_W'(i);
            grant_vec[i] = 1'b1;
         end
      end
   end

   // Accept is the grant gated by output space; nothing is taken while in reset
   always_comb begin
      bus.in_ready = '0;
      if (!rst && load_en) begin
         bus.in_ready = grant_vec;
      end
   end

   // Next-state: load granted beat, drain to empty when idle, or hold under backpressure
   always_comb begin
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (load_en) begin
         if (grant_any) begin
            out_data_d  = bus.in_data[grant_idx];
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            if (grant_idx == SEL_W'(NUM_OF_INPUTS - 1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = grant_idx + 1'b1;
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // State registers; reset discards any held beat and restarts the search at channel 0
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_mux_nbit.sv
// tb/tb_rr_mux_nbit.sv - directed vector bench for rr_mux_nbit (N=5/W=4, N=2/W=1, N=16/W=32)
module tb_rr_mux_nbit;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   rr_mux_nbit_if #(.NUM_OF_INPUTS(5),  .INPUT_WIDTH(4))  b5 ();
   rr_mux_nbit_if #(.NUM_OF_INPUTS(2),  .INPUT_WIDTH(1))  b2 ();
   rr_mux_nbit_if #(.NUM_OF_INPUTS(16), .INPUT_WIDTH(32)) b16 ();

   rr_mux_nbit #(.NUM_OF_INPUTS(5),  .INPUT_WIDTH(4))  u5  (.clk(clk), .rst(rst), .bus(b5));
   rr_mux_nbit #(.NUM_OF_INPUTS(2),  .INPUT_WIDTH(1))  u2  (.clk(clk), .rst(rst), .bus(b2));
   rr_mux_nbit #(.NUM_OF_INPUTS(16), .INPUT_WIDTH(32)) u16 (.clk(clk), .rst(rst), .bus(b16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [4:0]  iv;
      logic        ordy;
      logic [19:0] d;
      logic [4:0]  e_rdy;
      logic        e_vld;
      logic [2:0]  e_sel;
      logic [3:0]  e_data;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [4:0] iv, input logic ordy, input logic [19:0] d,
                      input logic [4:0] e_rdy, input logic e_vld, input logic [2:0] e_sel,
                      input logic [3:0] e_data);
      vec_t v;
      v.rst = r; v.iv = iv; v.ordy = ordy; v.d = d;
      v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_sel = e_sel; v.e_data = e_data;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // Reset held two cycles with every channel requesting
      add(1'b1, 5'b11111, 1'b1, 20'h54321, 5'b00000, 1'b0, 3'd0, 4'h0);
      add(1'b1, 5'b11111, 1'b1, 20'h54321, 5'b00000, 1'b0, 3'd0, 4'h0);
      // Full contention: 0,1,2,3,4,0 at one beat per cycle
      add(1'b0, 5'b11111, 1'b1, 20'h54321, 5'b00001, 1'b1, 3'd0, 4'h1);
      add(1'b0, 5'b11111, 1'b1, 20'h54321, 5'b00010, 1'b1, 3'd1, 4'h2);
      add(1'b0, 5'b11111, 1'b1, 20'h54321, 5'b00100, 1'b1, 3'd2, 4'h3);
      add(1'b0, 5'b11111, 1'b1, 20'h54321, 5'b01000, 1'b1, 3'd3, 4'h4);
      add(1'b0, 5'b11111, 1'b1, 20'h54321, 5'b10000, 1'b1, 3'd4, 4'h5);
      add(1'b0, 5'b11111, 1'b1, 20'h54321, 5'b00001, 1'b1, 3'd0, 4'h1);
      // Backpressure: ch2 beat (0xA) held three cycles, then ch3 next
      add(1'b0, 5'b11111, 1'b1, 20'h54A21, 5'b00010, 1'b1, 3'd1, 4'h2);
      add(1'b0, 5'b11111, 1'b1, 20'h54A21, 5'b00100, 1'b1, 3'd2, 4'hA);
      add(1'b0, 5'b11111, 1'b0, 20'h54A21, 5'b00000, 1'b1, 3'd2, 4'hA);
      add(1'b0, 5'b11111, 1'b0, 20'h54A21, 5'b00000, 1'b1, 3'd2, 4'hA);
      add(1'b0, 5'b11111, 1'b0, 20'h54A21, 5'b00000, 1'b1, 3'd2, 4'hA);
      add(1'b0, 5'b11111, 1'b1, 20'h54A21, 5'b01000, 1'b1, 3'd3, 4'h4);
      // Sparse wrap from ptr=4 to ch1, then idle drains; ptr must stay 2
      add(1'b0, 5'b00010, 1'b1, 20'h54321, 5'b00010, 1'b1, 3'd1, 4'h2);
      add(1'b0, 5'b00000, 1'b1, 20'h54321, 5'b00000, 1'b0, 3'd1, 4'h2);
      add(1'b0, 5'b00000, 1'b0, 20'h54321, 5'b00000, 1'b0, 3'd1, 4'h2);
      add(1'b0, 5'b11111, 1'b0, 20'h54321, 5'b00100, 1'b1, 3'd2, 4'h3);
      add(1'b0, 5'b11111, 1'b0, 20'h54321, 5'b00000, 1'b1, 3'd2, 4'h3);
      // Reset mid-stream with out_sel=3 held, then restart at ch0
      add(1'b0, 5'b11111, 1'b1, 20'h54321, 5'b01000, 1'b1, 3'd3, 4'h4);
      add(1'b1, 5'b11111, 1'b0, 20'h54321, 5'b00000, 1'b0, 3'd0, 4'h0);
      add(1'b0, 5'b11111, 1'b1, 20'h54321, 5'b00001, 1'b1, 3'd0, 4'h1);
      add(1'b0, 5'b10000, 1'b1, 20'h54321, 5'b10000, 1'b1, 3'd4, 4'h5);
      add(1'b0, 5'b10001, 1'b1, 20'h54321, 5'b00001, 1'b1, 3'd0, 4'h1);

      // Sweep instances stay idle during the N=5 table
      b2.in_valid  = '0;
      b2.out_ready = 1'b1;
      b2.in_data[0] = 1'b1;
      b2.in_data[1] = 1'b0;
      b16.in_valid  = '0;
      b16.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) b16.in_data[i] = 32'(i + 1);

      foreach (vecs[n]) begin
         rst          = vecs[n].rst;
         b5.in_valid  = vecs[n].iv;
         b5.out_ready = vecs[n].ordy;
         for (int i = 0; i < 5; i++) b5.in_data[i] = vecs[n].d[4*i +: 4];
         #1;
         check($sformatf("v%0d_in_ready", n), 32'(b5.in_ready), 32'(vecs[n].e_rdy));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_out_valid", n), 32'(b5.out_valid), 32'(vecs[n].e_vld));
         check($sformatf("v%0d_out_sel", n),   32'(b5.out_sel),   32'(vecs[n].e_sel));
         check($sformatf("v%0d_out_data", n),  32'(b5.out_data),  32'(vecs[n].e_data));
      end

      // Parameter sweep: full contention on N=2 and N=16, both fresh from reset
      rst = 1'b0;
      b5.in_valid  = '0;
      b2.in_valid  = 2'b11;
      b16.in_valid = 16'hFFFF;
      for (int k = 0; k < 20; k++) begin
         #1;
         check($sformatf("n2_c%0d_in_ready", k),  32'(b2.in_ready),  32'(2'b01 << (k % 2)));
         check($sformatf("n16_c%0d_in_ready", k), 32'(b16.in_ready), 32'(16'h0001 << (k % 16)));
         @(posedge clk);
         #1;
         check($sformatf("n2_c%0d_out_valid", k),  32'(b2.out_valid),  32'd1);
         check($sformatf("n2_c%0d_out_sel", k),    32'(b2.out_sel),    32'(k % 2));
         check($sformatf("n2_c%0d_out_data", k),   32'(b2.out_data),   32'((k % 2) == 0 ? 1 : 0));
         check($sformatf("n16_c%0d_out_valid", k), 32'(b16.out_valid), 32'd1);
         check($sformatf("n16_c%0d_out_sel", k),   32'(b16.out_sel),   32'(k % 16));
         check($sformatf("n16_c%0d_out_data", k),  b16.out_data,       32'((k % 16) + 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
